// File: rtl/rgen_host_if_pkg.sv
// Shared types and constants for the register-generator host interfaces.
package rgen_host_if_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY     = 2'd1,
    RESPONSE = 2'd2
  } state_t;

  // Bit of the local status word that flags an error response.
  localparam int STATUS_ERROR_BIT = 0;

  // APB PPROT bit positions.
  localparam int PPROT_PRIVILEGED = 0;
  localparam int PPROT_NONSECURE  = 1;

endpackage

// File: rtl/rgen_host_if_watchdog.sv
// Response-timeout counter for host interfaces: counts enabled cycles since the
// last clear and flags expiry on the LIMIT-th enabled cycle.
module rgen_host_if_watchdog #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (LIMIT > 0) ? (($clog2(LIMIT + 1) > 0) ? $clog2(LIMIT + 1) : 1) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count_q;

  assign expire = enable && (count_q == LAST);

  // Count enabled cycles; hold at the terminal value so the counter never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expire) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/rgen_host_if_apb_buffered.sv
// APB host interface with registered command and response stages, PPROT
// filtering and an optional response watchdog.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for an APB setup phase; captures address/data/mask
//   BUSY     | local command presented, waiting for response or timeout
//   RESPONSE | o_pready pulsed for one cycle with captured prdata/pslverr
module rgen_host_if_apb_buffered
  import rgen_host_if_pkg::*;
#(
  parameter int DATA_WIDTH          = 32,
  parameter int HOST_ADDRESS_WIDTH  = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES      = 0,
  parameter int PRIVILEGED_ONLY     = 0,
  parameter int SECURE_ONLY         = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [HOST_ADDRESS_WIDTH-1:0]  i_paddr,
  input  logic [2:0]                     i_pprot,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic                           i_pwrite,
  input  logic [DATA_WIDTH-1:0]          i_pwdata,
  input  logic [DATA_WIDTH/8-1:0]        i_pstrb,
  output logic                           o_pready,
  output logic [DATA_WIDTH-1:0]          o_prdata,
  output logic                           o_pslverr,
  output logic                           o_command_valid,
  output logic                           o_write,
  output logic                           o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]          o_write_data,
  output logic [DATA_WIDTH-1:0]          o_write_mask,
  input  logic                           i_response_ready,
  input  logic [DATA_WIDTH-1:0]          i_read_data,
  input  logic [1:0]                     i_status
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t state_q, state_d;

  logic                           write_q, write_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0]          write_data_d;
  logic [DATA_WIDTH-1:0]          write_mask_d;
  logic                           command_valid_d;
  logic                           write_cmd_d;
  logic                           read_cmd_d;
  logic                           pready_d;
  logic                           pslverr_d;
  logic [DATA_WIDTH-1:0]          prdata_d;

  logic [DATA_WIDTH-1:0]          strobe_mask;
  logic                           setup_phase;
  logic                           prot_violation;
  logic                           timeout_expire;

  // Upper host address bits, PPROT[2] and status[1] have no function here.
  logic unused_inputs;
  assign unused_inputs = ^{i_paddr, i_pprot, i_status};

  assign setup_phase    = i_psel && !i_penable;
  assign prot_violation = ((PRIVILEGED_ONLY != 0) && !i_pprot[PPROT_PRIVILEGED]) ||
                          ((SECURE_ONLY != 0) && i_pprot[PPROT_NONSECURE]);

  // Expand byte strobes into a per-bit write mask.
  always_comb begin
    strobe_mask = '0;
    for (int i = 0; i < STRB_WIDTH; i++) begin
      strobe_mask[8*i +: 8] = {8{i_pstrb[i]}};
    end
  end

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_watchdog
      rgen_host_if_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
      ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != BUSY),
        .enable (state_q == BUSY),
        .expire (timeout_expire)
      );
    end else begin : g_no_watchdog
      assign timeout_expire = 1'b0;
    end
  endgenerate

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    address_d       = o_address;
    write_data_d    = o_write_data;
    write_mask_d    = o_write_mask;
    command_valid_d = 1'b0;
    write_cmd_d     = 1'b0;
    read_cmd_d      = 1'b0;
    pready_d        = 1'b0;
    pslverr_d       = 1'b0;
    prdata_d        = o_prdata;

    case (state_q)
      IDLE: begin
        if (setup_phase) begin
          address_d    = i_paddr[LOCAL_ADDRESS_WIDTH-1:0];
          write_data_d = i_pwdata;
          write_mask_d = strobe_mask;
          write_d      = i_pwrite;
          if (prot_violation) begin
            state_d   = RESPONSE;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else begin
            state_d         = BUSY;
            command_valid_d = 1'b1;
            write_cmd_d     = i_pwrite;
            read_cmd_d      = !i_pwrite;
          end
        end
      end

      BUSY: begin
        // A response on the timeout cycle still counts as a normal completion.
        if (i_response_ready) begin
          state_d   = RESPONSE;
          pready_d  = 1'b1;
          pslverr_d = i_status[STATUS_ERROR_BIT];
          prdata_d  = write_q ? '0 : i_read_data;
        end else if (timeout_expire) begin
          state_d   = RESPONSE;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          prdata_d  = '0;
        end else begin
          command_valid_d = 1'b1;
          write_cmd_d     = write_q;
          read_cmd_d      = !write_q;
        end
      end

      RESPONSE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      write_q         <= 1'b0;
      o_address       <= '0;
      o_write_data    <= '0;
      o_write_mask    <= '0;
      o_command_valid <= 1'b0;
      o_write         <= 1'b0;
      o_read          <= 1'b0;
      o_pready        <= 1'b0;
      o_pslverr       <= 1'b0;
      o_prdata        <= '0;
    end else begin
      state_q         <= state_d;
      write_q         <= write_d;
      o_address       <= address_d;
      o_write_data    <= write_data_d;
      o_write_mask    <= write_mask_d;
      o_command_valid <= command_valid_d;
      o_write         <= write_cmd_d;
      o_read          <= read_cmd_d;
      o_pready        <= pready_d;
      o_pslverr       <= pslverr_d;
      o_prdata        <= prdata_d;
    end
  end

endmodule

// File: tb/tb_rgen_host_if_apb_buffered.sv
// Self-checking bench for the buffered APB host interface.
module tb_rgen_host_if_apb_buffered;

  localparam int DW   = 32;
  localparam int HAW  = 16;
  localparam int LAW  = 12;
  localparam int TMO  = 8;
  localparam int PRIV = 1;
  localparam int SEC  = 0;

  logic            clk;
  logic            rst_n;
  logic [HAW-1:0]  i_paddr;
  logic [2:0]      i_pprot;
  logic            i_psel;
  logic            i_penable;
  logic            i_pwrite;
  logic [DW-1:0]   i_pwdata;
  logic [DW/8-1:0] i_pstrb;
  logic            o_pready;
  logic [DW-1:0]   o_prdata;
  logic            o_pslverr;
  logic            o_command_valid;
  logic            o_write;
  logic            o_read;
  logic [LAW-1:0]  o_address;
  logic [DW-1:0]   o_write_data;
  logic [DW-1:0]   o_write_mask;
  logic            i_response_ready;
  logic [DW-1:0]   i_read_data;
  logic [1:0]      i_status;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [DW-1:0] prdata;
    logic          slverr;
    int            busy;
  } exp_t;

  exp_t sb_q[$];

  rgen_host_if_apb_buffered #(
    .DATA_WIDTH          (DW),
    .HOST_ADDRESS_WIDTH  (HAW),
    .LOCAL_ADDRESS_WIDTH (LAW),
    .TIMEOUT_CYCLES      (TMO),
    .PRIVILEGED_ONLY     (PRIV),
    .SECURE_ONLY         (SEC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_paddr          (i_paddr),
    .i_pprot          (i_pprot),
    .i_psel           (i_psel),
    .i_penable        (i_penable),
    .i_pwrite         (i_pwrite),
    .i_pwdata         (i_pwdata),
    .i_pstrb          (i_pstrb),
    .o_pready         (o_pready),
    .o_prdata         (o_prdata),
    .o_pslverr        (o_pslverr),
    .o_command_valid  (o_command_valid),
    .o_write          (o_write),
    .o_read           (o_read),
    .o_address        (o_address),
    .o_write_data     (o_write_data),
    .o_write_mask     (o_write_mask),
    .i_response_ready (i_response_ready),
    .i_read_data      (i_read_data),
    .i_status         (i_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer: expectation pushed at setup, popped when o_pready shows.
  task automatic run_xfer(input string name, input logic wr, input logic [HAW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW/8-1:0] strb,
                          input logic [2:0] prot, input int resp_cycle,
                          input logic [DW-1:0] rdata, input logic [1:0] status,
                          input logic drop_psel);
    exp_t          e;
    logic          viol;
    logic          tmo;
    logic [DW-1:0] mask;
    int            busy;
    int            lat;
    bit            done;

    viol = ((PRIV != 0) && !prot[0]) || ((SEC != 0) && prot[1]);
    tmo  = !viol && (resp_cycle <= 0 || resp_cycle > TMO);
    for (int i = 0; i < DW/8; i++) mask[8*i +: 8] = {8{strb[i]}};
    e.slverr = viol || tmo || status[0];
    e.prdata = (viol || tmo || wr) ? '0 : rdata;
    e.busy   = viol ? 0 : (tmo ? TMO : resp_cycle);
    sb_q.push_back(e);

    total++;
    if (o_pready !== 1'b0) $display("FAIL %s idle_pready got=%b want=0", name, o_pready);
    else passed++;

    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = wr; i_paddr = addr;
    i_pwdata = wdata; i_pstrb = strb; i_pprot = prot;
    step();
    if (drop_psel) begin i_psel = 1'b0; i_penable = 1'b0; end
    else i_penable = 1'b1;

    busy = 0; lat = 0; done = 0;
    while (!done && lat < 40) begin
      lat++;
      if (o_pready === 1'b1) begin
        done = 1;
        e = sb_q.pop_front();
        i_response_ready = 1'b0;
        total++;
        if (o_prdata !== e.prdata) $display("FAIL %s prdata got=%h want=%h", name, o_prdata, e.prdata);
        else passed++;
        total++;
        if (o_pslverr !== e.slverr) $display("FAIL %s pslverr got=%b want=%b", name, o_pslverr, e.slverr);
        else passed++;
        total++;
        if (busy !== e.busy) $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy, e.busy);
        else passed++;
        total++;
        if (lat !== e.busy + 1) $display("FAIL %s latency got=%0d want=%0d", name, lat, e.busy + 1);
        else passed++;
      end else begin
        if (o_command_valid === 1'b1) begin
          busy++;
          if (busy == 1) begin
            total++;
            if (o_address !== addr[LAW-1:0] || o_write_data !== wdata || o_write_mask !== mask ||
                o_write !== wr || o_read !== !wr)
              $display("FAIL %s command got=%h/%h/%h/%b%b want=%h/%h/%h/%b%b", name, o_address,
                       o_write_data, o_write_mask, o_write, o_read, addr[LAW-1:0], wdata, mask, wr, !wr);
            else passed++;
          end
          if (busy == resp_cycle) begin
            i_response_ready = 1'b1; i_read_data = rdata; i_status = status;
          end else begin
            i_response_ready = 1'b0; i_read_data = 32'hBAD0_BAD0; i_status = 2'b11;
          end
        end
        step();
      end
    end
    if (!done) begin
      total++;
      $display("FAIL %s pready_wait got=none want=pulse", name);
      sb_q.delete();
      i_response_ready = 1'b0;
    end
    step();
    i_psel = 1'b0; i_penable = 1'b0;
    total++;
    if (o_pready !== 1'b0 || o_command_valid !== 1'b0 || o_pslverr !== 1'b0)
      $display("FAIL %s after_pulse got=%b%b%b want=000", name, o_pready, o_command_valid, o_pslverr);
    else passed++;
    total++;
    if (o_prdata !== e.prdata) $display("FAIL %s prdata_hold got=%h want=%h", name, o_prdata, e.prdata);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_paddr = '0; i_pprot = '0; i_psel = 1'b0; i_penable = 1'b0; i_pwrite = 1'b0;
    i_pwdata = '0; i_pstrb = '0; i_response_ready = 1'b0; i_read_data = '0; i_status = '0;
    step(); step();
    total++;
    if ({o_pready, o_pslverr, o_command_valid, o_write, o_read} !== 5'b0 ||
        o_prdata !== '0 || o_address !== '0 || o_write_data !== '0 || o_write_mask !== '0)
      $display("FAIL reset_outputs got=%b%b%b%b%b/%h/%h want=all zero", o_pready, o_pslverr,
               o_command_valid, o_write, o_read, o_prdata, o_write_mask);
    else passed++;
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_no_setup_ignored();
    bit seen;
    seen = 0;
    i_psel = 1'b1; i_penable = 1'b1; i_pprot = 3'b001; i_pwrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_command_valid === 1'b1 || o_pready === 1'b1) seen = 1;
    end
    i_psel = 1'b0; i_penable = 1'b0;
    step();
    total++;
    if (seen !== 1'b0) $display("FAIL no_setup_ignored got=activity want=none");
    else passed++;
  endtask

  task automatic test_write_ok();
    run_xfer("write_ok", 1'b1, 16'h0010, 32'hDEADBEEF, 4'b0101, 3'b001, 1, 32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_delayed_read();
    run_xfer("delayed_read", 1'b0, 16'h0024, 32'h0, 4'b0000, 3'b001, 4, 32'h12345678, 2'b00, 1'b0);
    run_xfer("write_clears_prdata", 1'b1, 16'h0030, 32'h0BADF00D, 4'b1111, 3'b001, 2,
             32'hFFFF0000, 2'b00, 1'b0);
  endtask

  task automatic test_error_status();
    run_xfer("status_err", 1'b0, 16'h0040, 32'h0, 4'b0000, 3'b001, 2, 32'hCAFE0001, 2'b01, 1'b0);
    run_xfer("status_bit1", 1'b0, 16'h0044, 32'h0, 4'b0000, 3'b001, 1, 32'hCAFE0002, 2'b10, 1'b0);
  endtask

  task automatic test_timeout();
    run_xfer("timeout", 1'b0, 16'h0050, 32'h0, 4'b0000, 3'b001, 0, 32'h0, 2'b00, 1'b0);
    run_xfer("resp_on_last", 1'b0, 16'h0054, 32'h0, 4'b0000, 3'b001, TMO, 32'h5555AAAA, 2'b00, 1'b0);
    run_xfer("resp_before_last", 1'b1, 16'h0058, 32'h11223344, 4'b1000, 3'b001, TMO - 1,
             32'h0, 2'b00, 1'b0);
  endtask

  task automatic test_protection();
    run_xfer("prot_reject", 1'b1, 16'h0060, 32'hFEEDFACE, 4'b1111, 3'b000, 1, 32'h0, 2'b00, 1'b0);
    run_xfer("prot_accept", 1'b1, 16'h0060, 32'hFEEDFACE, 4'b0011, 3'b001, 1, 32'h0, 2'b00, 1'b0);
    run_xfer("prot_nonsecure_ok", 1'b0, 16'h0064, 32'h0, 4'b0000, 3'b011, 1, 32'h0F0F0F0F,
             2'b00, 1'b0);
  endtask

  task automatic test_psel_drop();
    run_xfer("psel_drop", 1'b0, 16'hF3A8, 32'h0, 4'b0000, 3'b101, 3, 32'hA5A55A5A, 2'b00, 1'b1);
  endtask

  task automatic test_reset_mid_busy();
    i_psel = 1'b1; i_penable = 1'b0; i_pwrite = 1'b0; i_paddr = 16'h0070; i_pprot = 3'b001;
    step();
    i_penable = 1'b1;
    total++;
    if (o_command_valid !== 1'b1) $display("FAIL mid_busy_cmd got=%b want=1", o_command_valid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_pready, o_pslverr, o_command_valid, o_write, o_read} !== 5'b0 ||
        o_prdata !== '0 || o_address !== '0 || o_write_mask !== '0)
      $display("FAIL async_reset got=%b%b%b%b%b/%h/%h want=all zero", o_pready, o_pslverr,
               o_command_valid, o_write, o_read, o_prdata, o_address);
    else passed++;
    i_psel = 1'b0; i_penable = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    run_xfer("after_reset", 1'b0, 16'h0074, 32'h0, 4'b0000, 3'b001, 2, 32'h87654321, 2'b00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_no_setup_ignored();
    test_write_ok();
    test_delayed_read();
    test_error_status();
    test_timeout();
    test_protection();
    test_psel_drop();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
